// File: rtl/popcount_neuron_sched.sv
// popcount_neuron_sched: time-multiplexes one external 27-input popcount core
// to evaluate a ternary neuron whose fan-in arrives as a stream of 27-bit
// chunks. Each chunk takes three cycles: accept (WAIT), add the positive
// popcount (POS), subtract the negative popcount (NEG). On the final chunk the
// saturated accumulator is compared against the thresholds sampled with the
// first chunk, and the result is held in OUT until the consumer takes it.
module popcount_neuron_sched #(
    parameter int MAX_CHUNKS = 8,
    parameter int ACC_W      = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [26:0]             in_x,
    input  logic [26:0]             in_wpos,
    input  logic [26:0]             in_wneg,
    input  logic                    in_last,
    input  logic signed [ACC_W-1:0] cfg_thr_hi,
    input  logic signed [ACC_W-1:0] cfg_thr_lo,
    output logic [26:0]             pc_in,
    input  logic [4:0]              pc_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_act,
    output logic signed [ACC_W-1:0] out_acc,
    output logic                    out_ovf
);

    localparam int CNT_W = 8;
    // Six guard bits hold acc +/- 31 without wrap for any ACC_W.
    localparam int EXT_W = ACC_W + 6;
    localparam logic [CNT_W-1:0]        MAX_CNT     = CNT_W'(MAX_CHUNKS);
    localparam logic signed [EXT_W-1:0] ACC_MAX_EXT = EXT_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] ACC_MIN_EXT = ~ACC_MAX_EXT;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_POS  = 2'd1,
        ST_NEG  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic [26:0]             pc_in_q, pc_in_d;
    logic                    out_valid_q, out_valid_d;
    logic [1:0]              out_act_q, out_act_d;
    logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [26:0]             neg_op_q, neg_op_d;
    logic                    last_q, last_d;
    logic signed [ACC_W-1:0] thr_hi_q, thr_hi_d;
    logic signed [ACC_W-1:0] thr_lo_q, thr_lo_d;

    logic signed [EXT_W-1:0] acc_ext;
    logic signed [EXT_W-1:0] pc_ext;
    logic signed [EXT_W-1:0] sum_pos;
    logic signed [EXT_W-1:0] sum_neg;
    logic [CNT_W-1:0]        cnt_inc;

    // Clamp a widened sum into the signed accumulator range.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [EXT_W-1:0] v);
        if (v > ACC_MAX_EXT) begin
            return ACC_MAX_EXT[ACC_W-1:0];
        end
        if (v < ACC_MIN_EXT) begin
            return ACC_MIN_EXT[ACC_W-1:0];
        end
        return v[ACC_W-1:0];
    endfunction

    // True when sat_acc would clamp this value.
    function automatic logic sat_hit(input logic signed [EXT_W-1:0] v);
        return (v > ACC_MAX_EXT) || (v < ACC_MIN_EXT);
    endfunction

    // Ternary decision; +1 is tested first so it wins when the thresholds overlap.
    function automatic logic [1:0] ternary_act(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] hi,
                                               input logic signed [ACC_W-1:0] lo);
        if (a >= hi) begin
            return 2'b01;
        end
        if (a <= lo) begin
            return 2'b11;
        end
        return 2'b00;
    endfunction

    assign acc_ext = {{6{acc_q[ACC_W-1]}}, acc_q};
    assign pc_ext  = {{(EXT_W - 5){1'b0}}, pc_out};
    assign sum_pos = acc_ext + pc_ext;
    assign sum_neg = acc_ext - pc_ext;
    assign cnt_inc = cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};

    // Next-state and datapath updates for the WAIT/POS/NEG/OUT sequence.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        pc_in_d     = pc_in_q;
        out_valid_d = out_valid_q;
        out_act_d   = out_act_q;
        out_acc_d   = out_acc_q;
        neg_op_d    = neg_op_q;
        last_d      = last_q;
        thr_hi_d    = thr_hi_q;
        thr_lo_d    = thr_lo_q;

        case (state_q)
            ST_WAIT: begin
                if (in_valid) begin
                    // The positive operand goes straight into the core register;
                    // the negative one is parked until the NEG cycle.
                    pc_in_d  = in_x & in_wpos;
                    neg_op_d = in_x & in_wneg;
                    last_d   = in_last;
                    state_d  = ST_POS;
                    if (cnt_q == '0) begin
                        thr_hi_d = cfg_thr_hi;
                        thr_lo_d = cfg_thr_lo;
                        acc_d    = '0;
                        ovf_d    = 1'b0;
                    end
                end
            end
            ST_POS: begin
                acc_d = sat_acc(sum_pos);
                if (sat_hit(sum_pos)) begin
                    ovf_d = 1'b1;
                end
                pc_in_d = neg_op_q;
                state_d = ST_NEG;
            end
            ST_NEG: begin
                acc_d = sat_acc(sum_neg);
                if (sat_hit(sum_neg)) begin
                    ovf_d = 1'b1;
                end
                cnt_d   = cnt_inc;
                pc_in_d = '0;
                if (last_q || (cnt_inc == MAX_CNT)) begin
                    if (!last_q) begin
                        ovf_d = 1'b1;
                    end
                    out_valid_d = 1'b1;
                    out_acc_d   = acc_d;
                    out_act_d   = ternary_act(acc_d, thr_hi_q, thr_lo_q);
                    state_d     = ST_OUT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // Control and output registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            pc_in_q     <= '0;
            out_valid_q <= 1'b0;
            out_act_q   <= 2'b00;
            out_acc_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            pc_in_q     <= pc_in_d;
            out_valid_q <= out_valid_d;
            out_act_q   <= out_act_d;
            out_acc_q   <= out_acc_d;
        end
    end

    // Chunk operands and thresholds; always rewritten before use, so no reset.
    always_ff @(posedge clk) begin
        neg_op_q <= neg_op_d;
        last_q   <= last_d;
        thr_hi_q <= thr_hi_d;
        thr_lo_q <= thr_lo_d;
    end

    assign in_ready  = (state_q == ST_WAIT);
    assign pc_in     = pc_in_q;
    assign out_valid = out_valid_q;
    assign out_act   = out_act_q;
    assign out_acc   = out_acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_popcount_neuron_sched.sv
// Bench for popcount_neuron_sched. Two instances: dut_a with default
// parameters and dut_b with MAX_CHUNKS=2, ACC_W=6; sel picks which one the
// shared stimulus and the result monitor talk to. Expected results are queued
// when a chunk is accepted and popped when the selected DUT hands a result out.
`timescale 1ns/1ps
module tb_popcount_neuron_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, in_valid, in_last, out_ready, sel, sat_mode;
    logic [26:0]        in_x, in_wpos, in_wneg;
    logic signed [9:0]  cfg_thr_hi, cfg_thr_lo;

    logic               a_in_ready, a_out_valid, a_out_ovf;
    logic [26:0]        a_pc_in;
    logic [4:0]         a_pc_out;
    logic [1:0]         a_out_act;
    logic signed [9:0]  a_out_acc;

    logic               b_in_ready, b_out_valid, b_out_ovf;
    logic [26:0]        b_pc_in;
    logic [4:0]         b_pc_out;
    logic [1:0]         b_out_act;
    logic signed [5:0]  b_out_acc;

    logic               m_in_ready, m_out_valid, m_out_ovf;
    logic [26:0]        m_pc_in;
    logic [1:0]         m_out_act;
    logic signed [9:0]  m_out_acc;

    typedef struct {
        int         acc;
        logic [1:0] act;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_acc    = 0;
    int   m_cnt    = 0;
    int   m_hi     = 0;
    int   m_lo     = 0;
    logic m_ovf    = 1'b0;

    // Popcount core stand-in: ideal, or forced to 31 on any non-zero operand.
    function automatic logic [4:0] core_model(input logic [26:0] v, input logic force31);
        if (force31 && (v != '0)) return 5'd31;
        return 5'($countones(v));
    endfunction

    assign a_pc_out = core_model(a_pc_in, sat_mode);
    assign b_pc_out = core_model(b_pc_in, sat_mode);

    popcount_neuron_sched #(.MAX_CHUNKS(8), .ACC_W(10)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
        .in_x(in_x), .in_wpos(in_wpos), .in_wneg(in_wneg), .in_last(in_last),
        .cfg_thr_hi(cfg_thr_hi), .cfg_thr_lo(cfg_thr_lo),
        .pc_in(a_pc_in), .pc_out(a_pc_out),
        .out_valid(a_out_valid), .out_ready(out_ready & ~sel),
        .out_act(a_out_act), .out_acc(a_out_acc), .out_ovf(a_out_ovf)
    );

    popcount_neuron_sched #(.MAX_CHUNKS(2), .ACC_W(6)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel), .in_ready(b_in_ready),
        .in_x(in_x), .in_wpos(in_wpos), .in_wneg(in_wneg), .in_last(in_last),
        .cfg_thr_hi(cfg_thr_hi[5:0]), .cfg_thr_lo(cfg_thr_lo[5:0]),
        .pc_in(b_pc_in), .pc_out(b_pc_out),
        .out_valid(b_out_valid), .out_ready(out_ready & sel),
        .out_act(b_out_act), .out_acc(b_out_acc), .out_ovf(b_out_ovf)
    );

    assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign m_out_valid = sel ? b_out_valid : a_out_valid;
    assign m_out_ovf   = sel ? b_out_ovf   : a_out_ovf;
    assign m_pc_in     = sel ? b_pc_in     : a_pc_in;
    assign m_out_act   = sel ? b_out_act   : a_out_act;
    assign m_out_acc   = sel ? {{4{b_out_acc[5]}}, b_out_acc} : a_out_acc;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Inputs change 1 ns after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference behaviour for one accepted chunk; queues a result when the
    // evaluation finishes.
    task automatic model_accept(input logic [26:0] x, input logic [26:0] wp,
                                input logic [26:0] wn, input logic last,
                                input int hi, input int lo);
        int w, maxc, lim_hi, lim_lo, p, n;
        logic [1:0] act;
        w      = sel ? 6 : 10;
        maxc   = sel ? 2 : 8;
        lim_hi = (1 << (w - 1)) - 1;
        lim_lo = -(1 << (w - 1));
        if (m_cnt == 0) begin
            m_hi = hi; m_lo = lo; m_acc = 0; m_ovf = 1'b0;
        end
        p = int'(core_model(x & wp, sat_mode));
        n = int'(core_model(x & wn, sat_mode));
        m_acc = m_acc + p;
        if (m_acc > lim_hi) begin m_acc = lim_hi; m_ovf = 1'b1; end
        m_acc = m_acc - n;
        if (m_acc < lim_lo) begin m_acc = lim_lo; m_ovf = 1'b1; end
        m_cnt++;
        if (last || (m_cnt == maxc)) begin
            if (!last) m_ovf = 1'b1;
            if (m_acc >= m_hi) act = 2'b01;
            else if (m_acc <= m_lo) act = 2'b11;
            else act = 2'b00;
            sb_q.push_back('{acc: m_acc, act: act, ovf: m_ovf});
            m_cnt = 0;
        end
    endtask

    // Offer one chunk; returns 1 ns after the falling edge of the POS cycle.
    task automatic send_chunk(input logic [26:0] x, input logic [26:0] wp,
                              input logic [26:0] wn, input logic last,
                              input int hi, input int lo);
        int waited = 0;
        in_x = x; in_wpos = wp; in_wneg = wn; in_last = last;
        cfg_thr_hi = 10'(hi); cfg_thr_lo = 10'(lo);
        in_valid = 1'b1;
        while (!m_in_ready && (waited < 50)) begin
            step();
            waited++;
        end
        if (!m_in_ready) begin
            check_eq("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        step();
        model_accept(x, wp, wn, last, hi, lo);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (sb_q.size() == 0) break;
            step();
        end
        check_eq("drain", sb_q.size(), 0);
        step();
    endtask

    // Result monitor: compares every completed handshake against the queue.
    always @(negedge clk) begin
        #2;
        if (!rst && m_out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_result", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("out_acc", m_out_acc, mon_e.acc);
                check_eq("out_act", m_out_act, mon_e.act);
                check_eq("out_ovf", m_out_ovf, mon_e.ovf);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    localparam logic [26:0] ONES = 27'h7FFFFFF;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        sel = 1'b0; sat_mode = 1'b0;
        in_x = '0; in_wpos = '0; in_wneg = '0; cfg_thr_hi = '0; cfg_thr_lo = '0;
        step(); step(); step();

        // Reset state
        check_eq("rst_in_ready", a_in_ready, 1);
        check_eq("rst_out_valid", a_out_valid, 0);
        check_eq("rst_pc_in", a_pc_in, 0);
        check_eq("rst_out_act", a_out_act, 0);
        check_eq("rst_out_acc", a_out_acc, 0);
        check_eq("rst_out_ovf", a_out_ovf, 0);
        check_eq("rst_b_out_valid", b_out_valid, 0);
        rst = 1'b0;
        step();

        // Single chunk: +8 -4 = 4, latency and core operand sequence
        send_chunk(ONES, 27'h00000FF, 27'h0000F00, 1'b1, 3, -3);
        check_eq("t1_pc_pos", m_pc_in, 27'h00000FF);
        check_eq("t1_valid_pos", m_out_valid, 0);
        step();
        check_eq("t1_pc_neg", m_pc_in, 27'h0000F00);
        check_eq("t1_valid_neg", m_out_valid, 0);
        step();
        check_eq("t1_valid_out", m_out_valid, 1);
        check_eq("t1_pc_out_idle", m_pc_in, 0);
        check_eq("t1_ready_out", m_in_ready, 0);
        step();
        check_eq("t1_valid_after", m_out_valid, 0);
        check_eq("t1_ready_after", m_in_ready, 1);
        wait_idle();

        // Three chunks of +2 -5, thresholds +/-4; in_ready runs 1,0,0
        for (int c = 0; c < 3; c++) begin
            send_chunk(ONES, 27'h0000003, 27'h00001F0, (c == 2), 4, -4);
            check_eq("t2_ready_pos", m_in_ready, 0);
            step();
            check_eq("t2_ready_neg", m_in_ready, 0);
            if (c < 2) begin
                step();
                check_eq("t2_ready_wait", m_in_ready, 1);
            end
        end
        wait_idle();

        // Backpressure: result held for 10 cycles
        out_ready = 1'b0;
        send_chunk(ONES, 27'h0000007, 27'h0000000, 1'b1, 2, -2);
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            check_eq("t4_hold_valid", m_out_valid, 1);
            check_eq("t4_hold_act", m_out_act, 2'b01);
            check_eq("t4_hold_acc", m_out_acc, 3);
            check_eq("t4_hold_ready", m_in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        check_eq("t4_released_valid", m_out_valid, 0);
        check_eq("t4_released_ready", m_in_ready, 1);
        wait_idle();

        // Overlapping thresholds (lo > hi): +1 wins at acc = 0
        send_chunk(ONES, 27'h0000000, 27'h0000000, 1'b1, -2, 5);
        wait_idle();
        // acc equal to the lower threshold gives -1
        send_chunk(ONES, 27'h0000000, 27'h000000F, 1'b1, 4, -4);
        wait_idle();

        // Reset during NEG of chunk 2 discards the evaluation
        send_chunk(ONES, 27'h0000007, 27'h0000001, 1'b0, 4, -4);
        step();
        step();
        send_chunk(ONES, 27'h0000007, 27'h0000001, 1'b0, 4, -4);
        step();
        rst = 1'b1;
        step();
        check_eq("t6_rst_ready", m_in_ready, 1);
        check_eq("t6_rst_valid", m_out_valid, 0);
        check_eq("t6_rst_pc_in", m_pc_in, 0);
        rst = 1'b0;
        m_cnt = 0; m_acc = 0; m_ovf = 1'b0;
        step();
        send_chunk(ONES, 27'h000003F, 27'h0000001, 1'b1, 4, -4);
        wait_idle();

        // Chunk limit (MAX_CHUNKS=2): four chunks without last
        sel = 1'b1;
        step();
        send_chunk(ONES, 27'h0000001, 27'h0000007, 1'b0, 3, -3);
        send_chunk(ONES, 27'h0000001, 27'h0000007, 1'b0, 3, -3);
        step();
        step();
        check_eq("t3_limit_valid", m_out_valid, 1);
        check_eq("t3_limit_ovf", m_out_ovf, 1);
        send_chunk(ONES, 27'h000001F, 27'h0000000, 1'b0, 3, -3);
        send_chunk(ONES, 27'h000001F, 27'h0000000, 1'b0, 3, -3);
        wait_idle();

        // Saturation with ACC_W=6: core reports 31 on every non-zero operand
        sat_mode = 1'b1;
        send_chunk(ONES, 27'h0000001, 27'h0000000, 1'b0, 10, -10);
        send_chunk(ONES, 27'h0000001, 27'h0000000, 1'b1, 10, -10);
        wait_idle();
        send_chunk(ONES, 27'h0000000, 27'h0000001, 1'b0, 10, -10);
        send_chunk(ONES, 27'h0000000, 27'h0000001, 1'b1, 10, -10);
        wait_idle();
        sat_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/popcount_neuron_sched.md
Name: popcount_neuron_sched

Overview:
Sequencing controller that time-multiplexes one external 27-input approximate popcount core to evaluate a ternary neuron over inputs wider than 27 bits.
- Activations arrive in 27-bit chunks with positive and negative weight masks.
- For each chunk the block drives the shared popcount twice: once with the positive-masked vector, once with the negative-masked vector.
- It accumulates the signed difference and, on the last chunk, emits a ternary activation.
- It sits between the sensor/input buffer and the next neuron layer.

Parameters:
- MAX_CHUNKS, 8, maximum chunks per neuron evaluation before a forced finish (1..255).
- ACC_W, 10, signed accumulator width in bits. The default covers ±31*8 with margin.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  chunk available.
- in_ready  output  1  block accepts a chunk this cycle.
- in_x  input  27  activation bits of the chunk.
- in_wpos  input  27  mask of +1 weights.
- in_wneg  input  27  mask of -1 weights.
- in_last  input  1  chunk is the final one of this neuron.
- cfg_thr_hi  input  ACC_W  signed upper threshold; sampled with the first chunk.
- cfg_thr_lo  input  ACC_W  signed lower threshold; sampled with the first chunk.
- pc_in  output  27  operand to the shared popcount core; driven from a register.
- pc_out  input  5  unsigned popcount result. The core is combinational and its result is valid in the same cycle.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_act  output  2  ternary activation: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0.
- out_acc  output  ACC_W  final signed accumulator.
- out_ovf  output  1  evaluation ended by the MAX_CHUNKS limit, or the accumulator saturated.

Behaviour:
States: WAIT, POS, NEG, OUT.

Reset:
- State goes to WAIT.
- acc, chunk count, pc_in, out_act, out_acc and out_ovf reset to 0; out_valid resets to 0.
- in_ready is 1 after reset.
- Reset mid-evaluation discards all partial state; no result is emitted.

WAIT:
- in_ready = 1 and pc_in = 0.
- On in_valid, register in_x&in_wpos and in_x&in_wneg and in_last, then go to POS.
- On the first chunk of an evaluation (chunk count = 0), also capture the thresholds and clear acc and the sticky overflow.

POS:
- pc_in = registered positive operand.
- acc <= sat(acc + pc_out), then go to NEG.

NEG:
- pc_in = registered negative operand.
- acc <= sat(acc - pc_out), and chunk count increments.
- Go to OUT if in_last was registered or the new count equals MAX_CHUNKS. In the count-limit case without last, out_ovf is set.
- Otherwise return to WAIT.

OUT:
- out_valid = 1 and out_acc = acc.
- out_act: +1 if acc >= thr_hi; else -1 if acc <= thr_lo; else 0. If thr_lo >= thr_hi, +1 has priority.
- Outputs are held stable until out_ready.
- The out_valid && out_ready handshake returns the block to WAIT and clears the chunk count; acc is cleared at the next first chunk.
- in_ready = 0 in POS, NEG and OUT.

Arithmetic:
- pc_out is zero-extended to ACC_W; the core is approximate and may report up to 31.
- sat() clamps to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1] and sets out_ovf (sticky) on a clamp.

Timing and boundaries:
- Latency: a chunk accepted at edge t is used in POS in cycle t+1 and NEG in cycle t+2.
- The next chunk is accepted in cycle t+3, giving a throughput of 1 chunk per 3 cycles.
- If the last chunk is accepted at edge t, out_valid rises at t+3.
- in_valid while in_ready = 0 is ignored; the source must hold its data.
- A single chunk with in_last = 1 is a valid 1-chunk neuron.
- out_ready may already be high when out_valid rises; that completes the handshake in one cycle.

Test Plan:
1. Single chunk:
   - Stimulus: in_x = all ones, wpos = 27'h00000FF (8 bits), wneg = 27'h0000F00 (4 bits), last = 1, thr_hi = 3, thr_lo = -3, ideal popcount model.
   - Response: pc_in = 27'h00000FF then 27'h0000F00; out_acc = 4, out_act = 01, out_valid at acceptance + 3 cycles.
2. Three chunks, each with pos count 2 and neg count 5, thresholds ±4:
   - Response: out_acc = -9, out_act = 11, in_ready pattern 1,0,0 repeating.
3. MAX_CHUNKS = 2, four chunks sent, none with last:
   - Response: result after chunk 2 with out_ovf = 1; chunks 3 and 4 start a new evaluation.
4. Backpressure: hold out_ready = 0 for 10 cycles in OUT.
   - Response: out_valid, out_act and out_acc stable; in_ready = 0; completion in the cycle out_ready = 1.
5. ACC_W = 6, core model returns 31 on every POS and 0 on every NEG, 3 chunks:
   - Response: acc saturates at 31, out_ovf = 1.
6. Assert rst during NEG of chunk 2:
   - Response: next cycle state WAIT, in_ready = 1, out_valid = 0; a fresh 1-chunk evaluation produces the correct standalone result.
